fp_encoder: RTL and testbench

FP_ENCODER -- requirements
Module: fp_encoder

---
 rtl/fp_pkg.sv | 48 ++++
 rtl/fp_lzc.sv | 21 ++
 rtl/fp_encoder.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_fp_encoder.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared constants and types for the floating-point result encoder.
// Rounding modes, FSM states, bias/limit constants and the rounding decision.
package fp_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rm_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NORM,
        ST_ROUND,
        ST_PACK,
        ST_DONE
    } state_e;

    localparam logic signed [15:0] DP_BIAS = 16'sd1023;
    localparam logic signed [15:0] SP_BIAS = 16'sd127;
    localparam logic signed [15:0] DP_EMAX = 16'sd2047;
    localparam logic signed [15:0] SP_EMAX = 16'sd255;

    localparam logic [63:0] DP_QNAN = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] SP_QNAN = 64'h0000_0000_7FC0_0000;

    // Encodings outside the defined set round to nearest-even.
    function automatic logic round_inc(
        input logic [2:0] rm,
        input logic       sign,
        input logic       guard,
        input logic       sticky,
        input logic       lsb
    );
        logic inc;
        case (rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = (guard | sticky) & sign;
            RM_RUP:  inc = (guard | sticky) & ~sign;
            RM_RMM:  inc = guard;
            default: inc = guard & (sticky | lsb);
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// 56-bit leading-zero counter; count is 56 when the input is all zeros.
module fp_lzc
    import fp_pkg::*;
(
    input  logic [55:0] data,
    output logic [5:0]  count,
    output logic        zero
);

    always_comb begin
        count = 6'd56;
        for (int i = 0; i < 56; i++) begin
            if (data[i]) begin
                count = 6'(55 - i);
            end
        end
    end

    assign zero = ~|data;

endmodule

// File: rtl/fp_encoder.sv
// Multi-cycle IEEE-754 encoder: normalize, round and pack a wide magnitude
// into single or double precision, with a valid/ready handshake each side.
module fp_encoder
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic signed [12:0] in_exp,
    input  logic [55:0]       in_mant,
    input  logic              in_is_zero,
    input  logic              in_is_inf,
    input  logic              in_is_nan,
    input  logic [2:0]        in_rm,
    input  logic              is_double_precision,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_result,
    output logic              flag_overflow,
    output logic              flag_underflow,
    output logic              flag_inexact
);

    state_e             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               sign_q, sign_d;
    logic               dp_q, dp_d;
    logic               nan_q, nan_d;
    logic               inf_q, inf_d;
    logic               zero_q, zero_d;
    logic [2:0]         rm_q, rm_d;
    logic signed [15:0] exp_q, exp_d;
    logic [55:0]        mant_q, mant_d;
    logic               tiny_q, tiny_d;
    logic [51:0]        frac_q, frac_d;
    logic               inexact_q, inexact_d;
    logic [63:0]        result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               inx_q, inx_d;

    logic [5:0]         lz;
    logic               lz_zero;

    logic [55:0]        shl;
    logic [55:0]        mask;
    logic [55:0]        mant_norm;
    logic signed [15:0] bias;
    logic signed [15:0] e_norm;
    logic signed [15:0] sh;
    logic [5:0]         sh_amt;
    logic               tiny_norm;

    logic [53:0]        kept;
    logic [53:0]        sum;
    logic               guard;
    logic               sticky;
    logic               lsb;
    logic               inc;
    logic               carry;
    logic               hidden;
    logic signed [15:0] e_round;
    logic [51:0]        frac_round;

    logic signed [15:0] emax;
    logic               ovf;
    logic               to_inf;
    logic [63:0]        inf_pat;
    logic [63:0]        max_pat;
    logic [63:0]        zero_pat;
    logic [63:0]        pack_res;
    logic               pack_ovf;
    logic               pack_unf;
    logic               pack_inx;

    fp_lzc u_lzc (
        .data  (mant_q),
        .count (lz),
        .zero  (lz_zero)
    );

    always_comb begin
        shl       = mant_q << lz;
        bias      = dp_q ? DP_BIAS : SP_BIAS;
        e_norm    = exp_q - $signed({10'd0, lz}) + bias;
        sh        = 16'sd1 - e_norm;
        sh_amt    = sh[5:0];
        mask      = ~({56{1'b1}} << sh_amt);
        mant_norm = shl;
        tiny_norm = 1'b0;
        // Below the normal range: denormalize, folding lost bits into sticky.
        if (e_norm <= 16'sd0) begin
            tiny_norm = 1'b1;
            if (sh >= 16'sd56) begin
                mant_norm = {55'd0, |shl};
            end else begin
                mant_norm = (shl >> sh_amt) | {55'd0, |(shl & mask)};
            end
            e_norm = 16'sd0;
        end

        if (dp_q) begin
            kept   = {1'b0, mant_q[55:3]};
            guard  = mant_q[2];
            sticky = |mant_q[1:0];
            lsb    = mant_q[3];
        end else begin
            kept   = {30'd0, mant_q[55:32]};
            guard  = mant_q[31];
            sticky = |mant_q[30:0];
            lsb    = mant_q[32];
        end
        inc     = round_inc(rm_q, sign_q, guard, sticky, lsb);
        sum     = kept + {53'd0, inc};
        carry   = dp_q ? sum[53] : sum[24];
        hidden  = dp_q ? sum[52] : sum[23];
        e_round = exp_q;
        if (carry) begin
            sum     = sum >> 1;
            e_round = exp_q + 16'sd1;
        end else if (exp_q == 16'sd0 && hidden) begin
            e_round = 16'sd1;
        end
        frac_round = dp_q ? sum[51:0] : {29'd0, sum[22:0]};

        emax   = dp_q ? DP_EMAX : SP_EMAX;
        ovf    = exp_q >= emax;
        case (rm_q)
            RM_RTZ:  to_inf = 1'b0;
            RM_RDN:  to_inf = sign_q;
            RM_RUP:  to_inf = ~sign_q;
            default: to_inf = 1'b1;
        endcase
        inf_pat  = dp_q ? {sign_q, 11'h7FF, 52'd0}
                        : {32'd0, sign_q, 8'hFF, 23'd0};
        max_pat  = dp_q ? {sign_q, 11'h7FE, {52{1'b1}}}
                        : {32'd0, sign_q, 8'hFE, {23{1'b1}}};
        zero_pat = dp_q ? {sign_q, 63'd0} : {32'd0, sign_q, 31'd0};
        pack_ovf = 1'b0;
        pack_unf = 1'b0;
        pack_inx = 1'b0;
        if (nan_q) begin
            pack_res = dp_q ? DP_QNAN : SP_QNAN;
        end else if (inf_q) begin
            pack_res = inf_pat;
        end else if (zero_q || lz_zero) begin
            pack_res = zero_pat;
        end else if (ovf) begin
            pack_res = to_inf ? inf_pat : max_pat;
            pack_ovf = 1'b1;
            pack_inx = 1'b1;
            pack_unf = tiny_q;
        end else begin
            pack_res = dp_q ? {sign_q, exp_q[10:0], frac_q}
                            : {32'd0, sign_q, exp_q[7:0], frac_q[22:0]};
            pack_inx = inexact_q;
            pack_unf = tiny_q & inexact_q;
        end

        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        sign_d      = sign_q;
        dp_d        = dp_q;
        nan_d       = nan_q;
        inf_d       = inf_q;
        zero_d      = zero_q;
        rm_d        = rm_q;
        exp_d       = exp_q;
        mant_d      = mant_q;
        tiny_d      = tiny_q;
        frac_d      = frac_q;
        inexact_d   = inexact_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        inx_d       = inx_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    sign_d     = in_sign;
                    dp_d       = is_double_precision;
                    nan_d      = in_is_nan;
                    inf_d      = in_is_inf;
                    zero_d     = in_is_zero;
                    rm_d       = in_rm;
                    exp_d      = {{3{in_exp[12]}}, in_exp};
                    mant_d     = in_mant;
                    in_ready_d = 1'b0;
                    state_d    = ST_NORM;
                end
            end
            ST_NORM: begin
                mant_d  = mant_norm;
                exp_d   = e_norm;
                tiny_d  = tiny_norm;
                state_d = ST_ROUND;
            end
            ST_ROUND: begin
                exp_d     = e_round;
                frac_d    = frac_round;
                inexact_d = guard | sticky;
                state_d   = ST_PACK;
            end
            ST_PACK: begin
                result_d    = pack_res;
                ovf_d       = pack_ovf;
                unf_d       = pack_unf;
                inx_d       = pack_inx;
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sign_q      <= 1'b0;
            dp_q        <= 1'b0;
            nan_q       <= 1'b0;
            inf_q       <= 1'b0;
            zero_q      <= 1'b0;
            rm_q        <= 3'd0;
            exp_q       <= 16'sd0;
            mant_q      <= 56'd0;
            tiny_q      <= 1'b0;
            frac_q      <= 52'd0;
            inexact_q   <= 1'b0;
            result_q    <= 64'd0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inx_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            sign_q      <= sign_d;
            dp_q        <= dp_d;
            nan_q       <= nan_d;
            inf_q       <= inf_d;
            zero_q      <= zero_d;
            rm_q        <= rm_d;
            exp_q       <= exp_d;
            mant_q      <= mant_d;
            tiny_q      <= tiny_d;
            frac_q      <= frac_d;
            inexact_q   <= inexact_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            inx_q       <= inx_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign out_result     = result_q;
    assign flag_overflow  = ovf_q;
    assign flag_underflow = unf_q;
    assign flag_inexact   = inx_q;

endmodule

// File: tb/tb_fp_encoder.sv
// Directed bench for fp_encoder: rounding, overflow, denormals, specials,
// handshake hold, throughput and mid-flight reset.
module tb_fp_encoder;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic signed [12:0] in_exp;
    logic [55:0]       in_mant;
    logic              in_is_zero;
    logic              in_is_inf;
    logic              in_is_nan;
    logic [2:0]        in_rm;
    logic              is_double_precision;
    logic              out_valid;
    logic              out_ready;
    logic [63:0]       out_result;
    logic              flag_overflow;
    logic              flag_underflow;
    logic              flag_inexact;

    int checks = 0;
    int errors = 0;

    localparam logic [55:0] ONE = 56'h80_0000_0000_0000;

    fp_encoder dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_sign             (in_sign),
        .in_exp              (in_exp),
        .in_mant             (in_mant),
        .in_is_zero          (in_is_zero),
        .in_is_inf           (in_is_inf),
        .in_is_nan           (in_is_nan),
        .in_rm               (in_rm),
        .is_double_precision (is_double_precision),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_result          (out_result),
        .flag_overflow       (flag_overflow),
        .flag_underflow      (flag_underflow),
        .flag_inexact        (flag_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one transaction from a negedge and returns at a negedge.
    // fl = {out_valid seen, overflow, underflow, inexact}.
    task automatic run_txn(
        input  logic              dp,
        input  logic              sign,
        input  logic signed [12:0] e,
        input  logic [55:0]       m,
        input  logic [2:0]        rm,
        input  logic              nan,
        input  logic              inf,
        input  logic              zero,
        input  logic              scramble,
        output logic [63:0]       res,
        output logic [3:0]        fl,
        output int                lat
    );
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        is_double_precision = dp;
        in_sign    = sign;
        in_exp     = e;
        in_mant    = m;
        in_rm      = rm;
        in_is_nan  = nan;
        in_is_inf  = inf;
        in_is_zero = zero;
        in_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        if (scramble) begin
            is_double_precision = ~dp;
            in_sign    = ~sign;
            in_exp     = 13'sd77;
            in_mant    = 56'h12_3456_789A_BCDE;
            in_rm      = 3'b001;
            in_is_nan  = 1'b1;
        end
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = out_result;
        fl  = {out_valid, flag_overflow, flag_underflow, flag_inexact};
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b exp 0", out_valid);
        end
        checks++;
        if (out_result !== 64'd0) begin
            errors++;
            $display("FAIL reset_result got %h exp 0", out_result);
        end
        checks++;
        if ({flag_overflow, flag_underflow, flag_inexact} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 000",
                     {flag_overflow, flag_underflow, flag_inexact});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b exp 1", in_ready);
        end
    endtask

    task automatic test_basic;
        logic [63:0] r;
        logic [3:0]  f;
        int          l;
        run_txn(1, 0, 0, ONE, 3'b000, 0, 0, 0, 0, r, f, l);
        checks++;
        if (r !== 64'h3FF0_0000_0000_0000) begin
            errors++;
            $display("FAIL dp_one got %h exp 3ff0000000000000", r);
        end
        checks++;
        if (f !== 4'b1000) begin
            errors++;
            $display("FAIL dp_one_flags got %b exp 1000", f);
        end
        checks++;
        if (l !== 4) begin
            errors++;
            $display("FAIL latency got %0d exp 4", l);
        end
        run_txn(1, 0, 13'sd5, 56'h04_0000_0000_0000, 3'b000, 0, 0, 0, 0,
                r, f, l);
        checks++;
        if (r !== 64'h3FF0_0000_0000_0000) begin
            errors++;
            $display("FAIL normalize got %h exp 3ff0000000000000", r);
        end
    endtask

    task automatic test_rounding;
        logic [63:0] r;
        logic [3:0]  f;
        int          l;
        logic [55:0] tie0;
        logic [55:0] tie1;
        tie0 = ONE | 56'h00_0000_8000_0000;
        tie1 = tie0 | 56'h00_0001_0000_0000;
        run_txn(0, 0, 0, tie0, 3'b000, 0, 0, 0, 0, r, f, l);
        checks++;
        if (r !== 64'h3F80_0000 || f !== 4'b1001) begin
            errors++;
            $display("FAIL sp_tie_rne got %h/%b exp 3f800000/1001", r, f);
        end
        run_txn(0, 0, 0, tie0, 3'b011, 0, 0, 0, 0, r, f, l);
        checks++;
        if (r !== 64'h3F80_0001 || f !== 4'b1001) begin
            errors++;
            $display("FAIL sp_tie_rup got %h/%b exp 3f800001/1001", r, f);
        end
        run_txn(0, 0, 0, tie0, 3'b100, 0, 0, 0, 0, r, f, l);
        checks++;
        if (r !== 64'h3F80_0001) begin
            errors++;
            $display("FAIL sp_tie_rmm got %h exp 3f800001", r);
        end
        run_txn(0, 0, 0, tie1, 3'b001, 0, 0, 0, 0, r, f, l);
        checks++;
        if (r !== 64'h3F80_0001) begin
            errors++;
            $display("FAIL sp_odd_rtz got %h exp 3f800001", r);
        end
        run_txn(0, 0, 0, tie1, 3'b111, 0, 0, 0, 0, r, f, l);
        checks++;
        if (r !== 64'h3F80_0002) begin
            errors++;
            $display("FAIL sp_odd_rm7 got %h exp 3f800002", r);
        end
        run_txn(1, 1, 0, ONE | 56'd1, 3'b010, 0, 0, 0, 0, r, f, l);
        checks++;
        if (r !== 64'hBFF0_0000_0000_0001 || f !== 4'b1001) begin
            errors++;
            $display("FAIL dp_neg_rdn got %h/%b exp bff0000000000001/1001",
                     r, f);
        end
        run_txn(1, 0, 0, 56'hFF_FFFF_FFFF_FFFC, 3'b000, 0, 0, 0, 0,
                r, f, l);
        checks++;
        if (r !== 64'h4000_0000_0000_0000 || f !== 4'b1001) begin
            errors++;
            $display("FAIL dp_carry got %h/%b exp 4000000000000000/1001",
                     r, f);
        end
    endtask

    task automatic test_overflow;
        logic [63:0] r;
        logic [3:0]  f;
        int          l;
        run_txn(1, 0, 13'sd1024, ONE, 3'b000, 0, 0, 0, 0, r, f, l);
        checks++;
        if (r !== 64'h7FF0_0000_0000_0000 || f !== 4'b1101) begin
            errors++;
            $display("FAIL dp_ovf_rne got %h/%b exp 7ff0000000000000/1101",
                     r, f);
        end
        run_txn(1, 0, 13'sd1024, ONE, 3'b001, 0, 0, 0, 0, r, f, l);
        checks++;
        if (r !== 64'h7FEF_FFFF_FFFF_FFFF || f !== 4'b1101) begin
            errors++;
            $display("FAIL dp_ovf_rtz got %h/%b exp 7fefffffffffffff/1101",
                     r, f);
        end
        run_txn(0, 0, 13'sd128, ONE, 3'b010, 0, 0, 0, 0, r, f, l);
        checks++;
        if (r !== 64'h7F7F_FFFF || f !== 4'b1101) begin
            errors++;
            $display("FAIL sp_ovf_rdn_pos got %h/%b exp 7f7fffff/1101", r, f);
        end
        run_txn(0, 1, 13'sd128, ONE, 3'b010, 0, 0, 0, 0, r, f, l);
        checks++;
        if (r !== 64'hFF80_0000 || f !== 4'b1101) begin
            errors++;
            $display("FAIL sp_ovf_rdn_neg got %h/%b exp ff800000/1101", r, f);
        end
    endtask

    task automatic test_subnormal;
        logic [63:0] r;
        logic [3:0]  f;
        int          l;
        run_txn(0, 0, -13'sd130, ONE, 3'b000, 0, 0, 0, 0, r, f, l);
        checks++;
        if (r !== 64'h0008_0000 || f !== 4'b1000) begin
            errors++;
            $display("FAIL sp_denorm got %h/%b exp 00080000/1000", r, f);
        end
        run_txn(0, 0, -13'sd130, ONE | 56'd1, 3'b000, 0, 0, 0, 0, r, f, l);
        checks++;
        if (r !== 64'h0008_0000 || f !== 4'b1011) begin
            errors++;
            $display("FAIL sp_denorm_sticky got %h/%b exp 00080000/1011", r, f);
        end
        run_txn(0, 0, -13'sd127, 56'hFF_FFFF_8000_0000, 3'b000, 0, 0, 0, 0,
                r, f, l);
        checks++;
        if (r !== 64'h0080_0000 || f !== 4'b1011) begin
            errors++;
            $display("FAIL sp_round_to_normal got %h/%b exp 00800000/1011",
                     r, f);
        end
        run_txn(1, 0, -13'sd1200, ONE, 3'b000, 0, 0, 0, 0, r, f, l);
        checks++;
        if (r !== 64'd0 || f !== 4'b1011) begin
            errors++;
            $display("FAIL dp_deep_rne got %h/%b exp 0/1011", r, f);
        end
        run_txn(1, 0, -13'sd1200, ONE, 3'b011, 0, 0, 0, 0, r, f, l);
        checks++;
        if (r !== 64'd1 || f !== 4'b1011) begin
            errors++;
            $display("FAIL dp_deep_rup got %h/%b exp 1/1011", r, f);
        end
    endtask

    task automatic test_special;
        logic [63:0] r;
        logic [3:0]  f;
        int          l;
        run_txn(1, 1, 0, ONE, 3'b000, 1, 1, 1, 0, r, f, l);
        checks++;
        if (r !== 64'h7FF8_0000_0000_0000 || f !== 4'b1000) begin
            errors++;
            $display("FAIL dp_nan got %h/%b exp 7ff8000000000000/1000", r, f);
        end
        run_txn(0, 1, 0, ONE, 3'b000, 0, 1, 1, 0, r, f, l);
        checks++;
        if (r !== 64'hFF80_0000 || f !== 4'b1000) begin
            errors++;
            $display("FAIL sp_neg_inf got %h/%b exp ff800000/1000", r, f);
        end
        run_txn(1, 1, 13'sd1024, ONE, 3'b000, 0, 0, 1, 0, r, f, l);
        checks++;
        if (r !== 64'h8000_0000_0000_0000 || f !== 4'b1000) begin
            errors++;
            $display("FAIL dp_neg_zero got %h/%b exp 8000000000000000/1000",
                     r, f);
        end
        run_txn(0, 1, 0, 56'd0, 3'b000, 0, 0, 0, 0, r, f, l);
        checks++;
        if (r !== 64'h8000_0000 || f !== 4'b1000) begin
            errors++;
            $display("FAIL sp_mant_zero got %h/%b exp 80000000/1000", r, f);
        end
    endtask

    task automatic test_capture;
        logic [63:0] r;
        logic [3:0]  f;
        int          l;
        run_txn(1, 0, 0, ONE, 3'b000, 0, 0, 0, 1, r, f, l);
        checks++;
        if (r !== 64'h3FF0_0000_0000_0000 || f !== 4'b1000) begin
            errors++;
            $display("FAIL capture got %h/%b exp 3ff0000000000000/1000", r, f);
        end
        in_is_nan = 1'b0;
    endtask

    task automatic test_hold;
        int w;
        is_double_precision = 1'b0;
        in_is_nan = 1'b1;
        in_is_inf = 1'b0;
        in_is_zero = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        in_is_nan = 1'b0;
        w = 0;
        while (!out_valid && w < 20) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_busy_ready got %b exp 0", in_ready);
            end
            @(negedge clk);
            w++;
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_result !== 64'h7FC0_0000 ||
                in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable got v=%b r=%h rdy=%b exp 1/7fc00000/0",
                         out_valid, out_result, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release got rdy=%b v=%b exp 1/0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back;
        int first;
        int second;
        int pulses;
        first  = -1;
        second = -1;
        pulses = 0;
        is_double_precision = 1'b1;
        in_sign  = 1'b0;
        in_exp   = 13'sd0;
        in_mant  = ONE;
        in_rm    = 3'b000;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (second >= 0) begin
                in_valid = 1'b0;
            end
            if (out_valid) begin
                pulses++;
            end
            if (in_ready && in_valid) begin
                if (first < 0) begin
                    first = i;
                end else if (second < 0) begin
                    second = i;
                end
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (first !== 0 || second !== 5) begin
            errors++;
            $display("FAIL b2b_accepts got %0d,%0d exp 0,5", first, second);
        end
        checks++;
        if (pulses !== 2) begin
            errors++;
            $display("FAIL b2b_results got %0d exp 2", pulses);
        end
    endtask

    task automatic test_reset_mid;
        logic seen;
        is_double_precision = 1'b1;
        in_mant  = ONE;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ready got %b exp 1", in_ready);
        end
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (out_valid !== 1'b0) begin
                seen = 1'b1;
            end
            @(negedge clk);
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midrst_valid got 1 exp 0");
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_idle got %b exp 1", in_ready);
        end
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_sign    = 1'b0;
        in_exp     = 13'sd0;
        in_mant    = 56'd0;
        in_is_zero = 1'b0;
        in_is_inf  = 1'b0;
        in_is_nan  = 1'b0;
        in_rm      = 3'b000;
        is_double_precision = 1'b1;
        out_ready  = 1'b0;
        test_reset;
        test_basic;
        test_rounding;
        test_overflow;
        test_subnormal;
        test_special;
        test_capture;
        test_hold;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
